// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge: SPI slave (one bit per clk) fronting a single-port RAM with
// independent write/read pointers, burst auto-increment and frame-error pulses.
module spi_ram_bridge #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);
    localparam int MAXW = ADDR_W > DATA_W ? ADDR_W : DATA_W;
    localparam int CW   = $clog2(MAXW + 1);

    typedef enum logic [2:0] {IDLE, CMD, WADDR, WDATA, RADDR, RTURN, RDATA, HOLD} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MAXW-1:0] in_sr_q, in_sr_d;
    logic [DATA_W-1:0] out_sr_q, out_sr_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic cmd_hi_q, cmd_hi_d, armed_q, armed_d, rd_oor_q, rd_oor_d;
    logic miso_q, miso_d, busy_q, err_q, err_d;
    logic mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, rdata_q, rd_word;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] p);
        return 32'(p) < MEM_DEPTH;
    endfunction

    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] p);
        return AUTO_INC == 0 ? p : (32'(p) == MEM_DEPTH - 1 ? '0 : p + 1'b1);
    endfunction

    assign MISO      = miso_q;
    assign busy      = busy_q;
    assign frame_err = err_q;
    assign rd_word   = rd_oor_q ? '0 : rdata_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_sr_d   = {in_sr_q[MAXW-2:0], MOSI};
        out_sr_d  = out_sr_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cmd_hi_d  = cmd_hi_q;
        armed_d   = armed_q | SS_n;
        rd_oor_d  = rd_oor_q;
        miso_d    = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = wptr_q;
        mem_wdata = in_sr_d[DATA_W-1:0];
        if (state_q != IDLE && SS_n) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = state_q == CMD || state_q == WADDR || state_q == RADDR ||
                      (state_q == WDATA && cnt_q != '0);
        end else begin
            case (state_q)
                IDLE: if (!SS_n && armed_q) begin
                    state_d  = CMD;
                    cmd_hi_d = MOSI;
                    cnt_d    = '0;
                end
                CMD: state_d = cmd_hi_q ? (MOSI ? RTURN : RADDR) : (MOSI ? WDATA : WADDR);
                WADDR, RADDR: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ADDR_W - 1)) begin
                        state_d = HOLD;
                        wptr_d  = state_q == WADDR ? in_sr_d[ADDR_W-1:0] : wptr_q;
                        rptr_d  = state_q == RADDR ? in_sr_d[ADDR_W-1:0] : rptr_q;
                    end
                end
                WDATA: begin
                    cnt_d = cnt_q == CW'(DATA_W - 1) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        mem_we = in_range(wptr_q);
                        err_d  = !in_range(wptr_q);
                        wptr_d = inc(wptr_q);
                    end
                end
                RTURN: begin
                    state_d  = RDATA;
                    cnt_d    = '0;
                    mem_addr = rptr_q;
                    mem_re   = in_range(rptr_q);
                    rd_oor_d = !in_range(rptr_q);
                end
                RDATA: begin
                    // word boundary loads the prefetched word; the last bit prefetches the next
                    miso_d   = cnt_q == '0 ? rd_word[DATA_W-1] : out_sr_q[DATA_W-1];
                    out_sr_d = (cnt_q == '0 ? rd_word : out_sr_q) << 1;
                    err_d    = cnt_q == '0 && rd_oor_q;
                    cnt_d    = cnt_q == CW'(DATA_W - 1) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        rptr_d   = inc(rptr_q);
                        mem_addr = rptr_d;
                        mem_re   = in_range(rptr_d);
                        rd_oor_d = !in_range(rptr_d);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            in_sr_q  <= '0;
            out_sr_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cmd_hi_q <= 1'b0;
            armed_q  <= 1'b0;
            rd_oor_q <= 1'b0;
            miso_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_sr_q  <= in_sr_d;
            out_sr_q <= out_sr_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cmd_hi_q <= cmd_hi_d;
            armed_q  <= armed_d;
            rd_oor_q <= rd_oor_d;
            miso_q   <= state_d == RDATA ? miso_d : 1'b0;
            busy_q   <= state_d != IDLE;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) rdata_q <= mem[mem_addr];
    end
endmodule

// File: tb/tb_spi_ram_bridge.sv
// tb_spi_ram_bridge: directed checks of three bridge configurations
// (default, AUTO_INC=0, MEM_DEPTH=200) driven bit by bit over SPI.
module tb_spi_ram_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] ss = 3'b111;
    logic [2:0] mosi = 3'b000;
    logic [2:0] miso, busy, ferr;
    int vec = 0;
    int bad = 0;
    int ferr_seen = 0;

    always #5 clk = ~clk;

    spi_ram_bridge u_def (.clk(clk), .rst(rst), .SS_n(ss[0]), .MOSI(mosi[0]),
                          .MISO(miso[0]), .busy(busy[0]), .frame_err(ferr[0]));
    spi_ram_bridge #(.AUTO_INC(0)) u_noinc (.clk(clk), .rst(rst), .SS_n(ss[1]), .MOSI(mosi[1]),
                          .MISO(miso[1]), .busy(busy[1]), .frame_err(ferr[1]));
    spi_ram_bridge #(.MEM_DEPTH(200)) u_d200 (.clk(clk), .rst(rst), .SS_n(ss[2]), .MOSI(mosi[2]),
                          .MISO(miso[2]), .busy(busy[2]), .frame_err(ferr[2]));

    task automatic clk_bit(input int d, input logic s, input logic m);
        @(negedge clk);
        ss[d]   = s;
        mosi[d] = m;
        @(posedge clk);
        #1;
        if (ferr[d]) ferr_seen++;
    endtask

    task automatic send(input int d, input logic [1:0] cmd, input logic [31:0] pl, input int nb);
        clk_bit(d, 1'b0, cmd[1]);
        clk_bit(d, 1'b0, cmd[0]);
        for (int i = 0; i < nb; i++) clk_bit(d, 1'b0, pl[nb-1-i]);
    endtask

    task automatic end_frame(input int d);
        clk_bit(d, 1'b1, 1'b0);
        clk_bit(d, 1'b1, 1'b0);
    endtask

    task automatic wr_addr(input int d, input logic [7:0] a);
        send(d, 2'b00, {24'b0, a}, 8);
        end_frame(d);
    endtask

    task automatic rd_addr(input int d, input logic [7:0] a);
        send(d, 2'b10, {24'b0, a}, 8);
        end_frame(d);
    endtask

    task automatic wr_words(input int d, input logic [31:0] w, input int n);
        send(d, 2'b01, w, 8 * n);
        end_frame(d);
    endtask

    task automatic rd_check(input int d, input int n, input logic [31:0] exp, input string name);
        logic [7:0] got;
        send(d, 2'b11, 32'b0, 1);
        for (int k = 0; k < n; k++) begin
            got = '0;
            for (int b = 0; b < 8; b++) begin
                clk_bit(d, 1'b0, 1'($urandom_range(0, 1)));
                got = {got[6:0], miso[d]};
            end
            vec++;
            if (got !== exp[8*(n-1-k) +: 8]) begin
                bad++;
                $display("FAIL %s word%0d: got %h expected %h", name, k, got, exp[8*(n-1-k) +: 8]);
            end
        end
        end_frame(d);
    endtask

    task automatic chk_err(input string name, input int expv);
        vec++;
        if (ferr_seen !== expv) begin
            bad++;
            $display("FAIL %s frame_err pulses: got %0d expected %0d", name, ferr_seen, expv);
        end
        ferr_seen = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            vec += 3;
            if (miso[d] !== 1'b0) begin bad++; $display("FAIL reset MISO dut%0d: got %b expected 0", d, miso[d]); end
            if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset busy dut%0d: got %b expected 0", d, busy[d]); end
            if (ferr[d] !== 1'b0) begin bad++; $display("FAIL reset frame_err dut%0d: got %b expected 0", d, ferr[d]); end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write_read;
        ferr_seen = 0;
        clk_bit(0, 1'b0, 1'b0);
        vec++;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL busy in frame: got %b expected 1", busy[0]); end
        send(0, 2'b0, 32'h10, 7);
        end_frame(0);
        wr_words(0, 32'hA5, 1);
        rd_addr(0, 8'h10);
        rd_check(0, 1, 32'hA5, "wr_rd_10");
        chk_err("wr_rd", 0);
    endtask

    task automatic test_burst;
        wr_addr(0, 8'hFE);
        wr_words(0, 32'h112233, 3);
        rd_addr(0, 8'hFE);
        rd_check(0, 3, 32'h112233, "burst_FE");
        rd_addr(0, 8'h00);
        rd_check(0, 1, 32'h33, "wrap_00");
        chk_err("burst", 0);
    endtask

    task automatic test_abort;
        wr_addr(0, 8'h40);
        wr_words(0, 32'h5A, 1);
        ferr_seen = 0;
        send(0, 2'b01, 32'b10110, 5);
        clk_bit(0, 1'b1, 1'b0);
        vec += 2;
        if (ferr[0] !== 1'b1) begin bad++; $display("FAIL abort wdata frame_err: got %b expected 1", ferr[0]); end
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL abort wdata busy: got %b expected 0", busy[0]); end
        clk_bit(0, 1'b1, 1'b0);
        vec++;
        if (ferr[0] !== 1'b0) begin bad++; $display("FAIL abort pulse width: got %b expected 0", ferr[0]); end
        chk_err("abort_wdata", 1);
        wr_words(0, 32'h3C, 1);
        rd_addr(0, 8'h41);
        rd_check(0, 1, 32'h3C, "wptr_kept");
        rd_addr(0, 8'h40);
        rd_check(0, 1, 32'h5A, "no_partial_write");
        clk_bit(0, 1'b0, 1'b1);
        clk_bit(0, 1'b1, 1'b0);
        end_frame(0);
        chk_err("abort_cmd", 1);
        rd_addr(0, 8'h10);
        send(0, 2'b11, 32'b0, 4);
        clk_bit(0, 1'b1, 1'b0);
        vec++;
        if (miso[0] !== 1'b0) begin bad++; $display("FAIL partial read MISO: got %b expected 0", miso[0]); end
        end_frame(0);
        chk_err("abort_rdata", 0);
    endtask

    task automatic test_noinc;
        wr_addr(1, 8'h06);
        wr_words(1, 32'h99, 1);
        wr_addr(1, 8'h05);
        wr_words(1, 32'h0102, 2);
        rd_addr(1, 8'h05);
        rd_check(1, 2, 32'h0202, "noinc_05");
        rd_addr(1, 8'h06);
        rd_check(1, 1, 32'h99, "noinc_06");
        chk_err("noinc", 0);
    endtask

    task automatic test_out_of_range;
        ferr_seen = 0;
        wr_addr(2, 8'hD0);
        wr_words(2, 32'h77, 1);
        chk_err("oor_write", 1);
        rd_addr(2, 8'hD0);
        rd_check(2, 1, 32'h00, "oor_read");
        chk_err("oor_read", 1);
        wr_addr(2, 8'hC7);
        wr_words(2, 32'hAABB, 2);
        rd_addr(2, 8'hC7);
        rd_check(2, 2, 32'hAABB, "d200_wrap");
        chk_err("d200_wrap", 0);
    endtask

    task automatic test_reset_mid_read;
        rd_addr(0, 8'h10);
        send(0, 2'b11, 32'b0, 4);
        vec++;
        if (miso[0] !== 1'b1) begin bad++; $display("FAIL mid read MISO: got %b expected 1", miso[0]); end
        #2 rst = 1'b1;
        #1;
        vec += 2;
        if (miso[0] !== 1'b0) begin bad++; $display("FAIL async rst MISO: got %b expected 0", miso[0]); end
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL async rst busy: got %b expected 0", busy[0]); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) clk_bit(0, 1'b0, 1'b1);
        vec++;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL no frame without SS_n edge: busy %b expected 0", busy[0]); end
        end_frame(0);
        rd_addr(0, 8'h10);
        rd_check(0, 1, 32'hA5, "after_rst");
        ferr_seen = 0;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_burst;
        test_abort;
        test_noinc;
        test_out_of_range;
        test_reset_mid_read;
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
